branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have parameter IDX_W, default 5, setting the pattern-history-table (PHT) index and global-history width.
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the statistics counter width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset; the ports are named as in the codebase (clk, rst).
REQ-004 The ports SHALL be:
- clk  in  1  clock.
- rst  in  1  async reset, active-high.
- hold  in  1  pipeline stall; when high, EX contents are not resolved.
- Branch_EX  in  1  EX holds beq/bne.
- bne_EX  in  1  1=bne, 0=beq.
- zero_EX  in  1  ALU zero flag for the EX compare.
- prediction_EX  in  1  prediction made at fetch.
- PCPlus1_EX  in  10  fall-through PC.
- BranchAddress_EX  in  10  branch target.
- Branch_state_EX  in  10  PHT index carried from fetch; bits [IDX_W-1:0] are used.
- ctr_rd  in  2  PHT counter read at Branch_state_EX index.
- taken  out  1  resolved outcome.
- mispredict  out  1  redirect request to fetch.
- redirect_PC  out  10  correct next PC.
- flush_IF, flush_ID  out  1 each  squash younger stages.
- pht_we  out  1  PHT write enable.
- pht_idx  out  IDX_W  PHT write index.
- pht_wdata  out  2  new counter value.
- ghr  out  IDX_W  committed global history.
- branch_cnt, mispred_cnt  out  CNT_W each  statistics counters.

Function
REQ-005 taken SHALL be combinational: Branch_EX & (bne_EX ? ~zero_EX : zero_EX).
REQ-006 A branch SHALL be resolved in a cycle iff Branch_EX=1 and hold=0.
REQ-007 mispredict SHALL equal resolved & (prediction_EX ^ taken), combinationally, in the same cycle.
REQ-008 redirect_PC SHALL be BranchAddress_EX when taken=1, else PCPlus1_EX; it is valid only while mispredict=1.
REQ-009 flush_IF and flush_ID SHALL equal mispredict, so the fetched wrong-path instructions are squashed in the cycle the redirect is taken.
REQ-010 The PHT update SHALL have one-cycle latency: a branch resolved in cycle N gives pht_we=1 in cycle N+1, with pht_idx = registered Branch_state_EX[IDX_W-1:0].
REQ-011 pht_wdata SHALL be the 2-bit saturating update of the base counter: increment when taken (saturating at 3), decrement when not taken (saturating at 0).
REQ-012 The base counter SHALL be ctr_rd sampled in cycle N.
REQ-013 Bypass: if a write is pending in cycle N (pht_we=1) to the same index being resolved in cycle N, the base counter SHALL be the pending pht_wdata instead of ctr_rd.
REQ-014 pht_we SHALL be 0 in any cycle not following a resolution.
REQ-015 ghr SHALL be a register that shifts to {ghr[IDX_W-2:0], taken} on each resolution and is otherwise unchanged.
REQ-016 branch_cnt SHALL increment by 1 on each resolution.
REQ-017 mispred_cnt SHALL increment by 1 on each mispredict.
REQ-018 Both counters SHALL saturate at all-ones and never wrap.
REQ-019 With hold=1, there SHALL be no mispredict, no flush, no PHT write scheduled, no GHR shift and no count, even if Branch_EX=1; the branch is resolved on the first cycle hold drops.
REQ-020 Back-to-back resolutions SHALL each produce their own pht_we cycle, with no loss or merge.

Reset
REQ-021 When rst is asserted, all registers SHALL clear asynchronously: pht_we=0, pht_idx=0, pht_wdata=0, ghr=0, branch_cnt=0, mispred_cnt=0.
REQ-022 A PHT write pending when rst is asserted SHALL be discarded.
REQ-023 Combinational outputs SHALL follow their inputs during reset, but mispredict and the flushes SHALL be forced to 0 while rst=1.
REQ-024 Normal operation SHALL resume on the first clock edge after rst deasserts.

Verification
REQ-025 beq, zero=1, prediction=0, ctr_rd=1, idx=7 -> same cycle: taken=1, mispredict=1, redirect_PC=BranchAddress_EX, flushes=1; next cycle: pht_we=1, pht_idx=7, pht_wdata=2, ghr LSB=1, mispred_cnt=1.
REQ-026 bne, zero=1, prediction=0, ctr_rd=0 -> taken=0, mispredict=0; next cycle pht_wdata=0 (saturation at 0); branch_cnt=1, mispred_cnt=0.
REQ-027 Two consecutive taken branches to idx 3, ctr_rd held at 2 both cycles -> writes of 3 then 3 (bypass, counter saturates at 3), never 3 then 2.
REQ-028 Branch_EX=1, mispredicting, with hold=1 for 3 cycles and then 0 -> no flush, write or count during the hold; exactly one resolution after hold drops.
REQ-029 Preload branch_cnt to all-ones via a long run of resolutions -> counter stays at FFFF; rst pulsed mid-cycle while pht_we is pending -> pht_we=0 immediately, and all counters and ghr read 0.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage beq/bne resolution (taken/mispredict/redirect/flush), 1-cycle PHT update with bypass, GHR and saturating stats
module branch_resolve #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             Branch_EX,
  input  logic             bne_EX,
  input  logic             zero_EX,
  input  logic             prediction_EX,
  input  logic [9:0]       PCPlus1_EX,
  input  logic [9:0]       BranchAddress_EX,
  input  logic [9:0]       Branch_state_EX,
  input  logic [1:0]       ctr_rd,
  output logic             taken,
  output logic             mispredict,
  output logic [9:0]       redirect_PC,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_idx,
  output logic [1:0]       pht_wdata,
  output logic [IDX_W-1:0] ghr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  logic             resolved;
  logic [IDX_W-1:0] idx;
  logic [1:0]       base;
  logic [1:0]       next_ctr;
  logic             unused_state;
  assign unused_state = &{1'b0, Branch_state_EX[9:IDX_W]};
  assign taken       = Branch_EX & (bne_EX ? ~zero_EX : zero_EX);
  assign resolved    = Branch_EX & ~hold;
  assign mispredict  = ~rst & resolved & (prediction_EX ^ taken);
  assign redirect_PC = taken ? BranchAddress_EX : PCPlus1_EX;
  assign flush_IF    = mispredict;
  assign flush_ID    = mispredict;
  assign idx         = Branch_state_EX[IDX_W-1:0];
  assign base        = (pht_we && pht_idx == idx) ? pht_wdata : ctr_rd;
  assign next_ctr    = taken ? ((base == 2'd3) ? base : base + 2'd1)
                             : ((base == 2'd0) ? base : base - 2'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht_we      <= 1'b0;
      pht_idx     <= '0;
      pht_wdata   <= '0;
      ghr         <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      pht_we <= resolved;
      if (resolved) begin
        pht_idx    <= idx;
        pht_wdata  <= next_ctr;
        ghr        <= {ghr[IDX_W-2:0], taken};
        branch_cnt <= (&branch_cnt) ? branch_cnt : branch_cnt + CNT_W'(1);
      end
      if (mispredict)
        mispred_cnt <= (&mispred_cnt) ? mispred_cnt : mispred_cnt + CNT_W'(1);
    end
  end
endmodule
